// File: rtl/led_pattern_gen_if.sv
// Pin bundle between the LED pattern generator and its board-level output buffers.
interface led_pattern_gen_if;
  logic       en;
  logic [1:0] mode;
  logic [3:0] led_o;
  logic       diff_o;
  logic       tick_o;

  modport master (output en, mode, input led_o, diff_o, tick_o);
  modport slave  (input en, mode, output led_o, diff_o, tick_o);
endinterface

// File: rtl/led_pattern_gen.sv
// Prescaled LED pattern generator: binary count, bouncing walk, PWM breathing or off,
// with a registered single-ended copy of LED 0 for the differential output buffer.
module led_pattern_gen #(
  parameter int unsigned LOG2DELAY = 25,
  parameter int unsigned PWM_BITS  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  led_pattern_gen_if.slave   bus
);

  typedef enum logic [1:0] {
    MODE_COUNT   = 2'd0,
    MODE_WALK    = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_OFF     = 2'd3
  } mode_e;

  mode_e                mode_q;
  logic [LOG2DELAY-1:0] presc;
  logic                 tick_q;
  logic [PWM_BITS-1:0]  pwm_cnt;
  logic [PWM_BITS-1:0]  duty;
  logic                 duty_up;
  logic [3:0]           count;
  logic [3:0]           walk;
  logic                 walk_up;
  logic [3:0]           led_q;
  logic                 diff_q;

  logic [3:0]           walk_nxt;
  logic [PWM_BITS-1:0]  duty_nxt;
  logic [3:0]           led_d;
  mode_e                mode_in;

  always_comb begin
    mode_in  = mode_e'(bus.mode);
    walk_nxt = walk_up ? {walk[2:0], 1'b0} : {1'b0, walk[3:1]};
    duty_nxt = duty_up ? duty + PWM_BITS'(1) : duty - PWM_BITS'(1);
    led_d    = '0;
    case (mode_q)
      MODE_COUNT:   led_d = count;
      MODE_WALK:    led_d = walk;
      MODE_BREATHE: led_d = {4{pwm_cnt < duty}};
      default:      led_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_OFF;
      presc   <= '0;
      tick_q  <= 1'b0;
      pwm_cnt <= '0;
      duty    <= '0;
      duty_up <= 1'b1;
      count   <= '0;
      walk    <= 4'b0001;
      walk_up <= 1'b1;
      led_q   <= '0;
      diff_q  <= 1'b0;
    end else begin
      // tick_q is cleared whenever en is low, so a held-off tick never lingers
      tick_q <= bus.en && (presc == '1);
      if (bus.en) begin
        presc   <= presc + LOG2DELAY'(1);
        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      end

      // The pattern update itself does not look at en: a tick already issued is honoured
      if (tick_q) begin
        if (mode_in != mode_q) begin
          mode_q  <= mode_in;
          count   <= '0;
          walk    <= 4'b0001;
          walk_up <= 1'b1;
          duty    <= '0;
          duty_up <= 1'b1;
        end else begin
          case (mode_q)
            MODE_COUNT: count <= count + 4'd1;
            MODE_WALK: begin
              walk <= walk_nxt;
              if (walk_nxt == 4'b1000) walk_up <= 1'b0;
              if (walk_nxt == 4'b0001) walk_up <= 1'b1;
            end
            MODE_BREATHE: begin
              duty <= duty_nxt;
              if (duty_nxt == '1) duty_up <= 1'b0;
              if (duty_nxt == '0) duty_up <= 1'b1;
            end
            default: ;
          endcase
        end
      end

      led_q  <= led_d;
      diff_q <= led_d[0];
    end
  end

  assign bus.led_o  = led_q;
  assign bus.diff_o = diff_q;
  assign bus.tick_o = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomised bench for led_pattern_gen, compared every cycle against a tick/step-count model.
module tb_led_pattern_gen;

  localparam int L2D    = 2;
  localparam int PWB    = 2;
  localparam int PERIOD = 1 << L2D;
  localparam int PMAX   = (1 << PWB) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  led_pattern_gen_if bus ();

  led_pattern_gen #(
    .LOG2DELAY (L2D),
    .PWM_BITS  (PWB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: enabled-cycle count, pending tick, active mode, advances since load
  int         ecnt;
  bit         tick_m;
  int         mode_m;
  int         steps;
  logic [3:0] led_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] pattern(input int md, input int s, input int pwm);
    int r;
    int d;
    case (md)
      0: return 4'(s % 16);
      1: case (s % 6)
           0: return 4'b0001;
           1: return 4'b0010;
           2: return 4'b0100;
           3: return 4'b1000;
           4: return 4'b0100;
           default: return 4'b0010;
         endcase
      2: begin
        r = s % (2 * PMAX);
        d = (r <= PMAX) ? r : 2 * PMAX - r;
        return (pwm < d) ? 4'hF : 4'h0;
      end
      default: return 4'h0;
    endcase
  endfunction

  task automatic model_reset();
    ecnt   = 0;
    tick_m = 1'b0;
    mode_m = 3;
    steps  = 0;
    led_m  = 4'h0;
  endtask

  task automatic model_edge();
    logic [3:0] nxt;
    if (!rst_n) begin
      model_reset();
      return;
    end
    nxt = pattern(mode_m, steps, ecnt % (PMAX + 1));
    if (tick_m) begin
      if (int'(bus.mode) != mode_m) begin
        mode_m = int'(bus.mode);
        steps  = 0;
      end else if (mode_m != 3) begin
        steps++;
      end
    end
    tick_m = bus.en && ((ecnt % PERIOD) == PERIOD - 1);
    if (bus.en) ecnt++;
    led_m = nxt;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("led_o", bus.led_o, led_m);
    check_eq("diff_o", bus.diff_o, led_m[0]);
    check_eq("tick_o", bus.tick_o, tick_m);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    bit found;
    model_reset();
    bus.en   = 1'b1;
    bus.mode = 2'd0;

    // Asynchronous reset before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_led", bus.led_o, 4'h0);
    check_eq("rst_diff", bus.diff_o, 1'b0);
    check_eq("rst_tick", bus.tick_o, 1'b0);
    run(3);
    rst_n = 1'b1;

    // Count: load tick plus 18 advances, covering the 1111->0000 wrap
    run(PERIOD * 20);

    // Walk and breathe
    bus.mode = 2'd1;
    run(PERIOD * 12);
    bus.mode = 2'd2;
    run(PERIOD * 10);

    // Enable gating mid-period, then a drop during the tick cycle itself
    bus.mode = 2'd0;
    run(PERIOD * 3 + 1);
    bus.en = 1'b0;
    run(7);
    bus.en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 4 * PERIOD && !found; i++) begin
      if (tick_m) found = 1'b1;
      else cycle();
    end
    check_eq("reach_tick", found, 1'b1);
    bus.en = 1'b0;
    run(3);
    bus.en = 1'b1;
    run(PERIOD * 2);

    // Mode switch between ticks at count 0101
    found = 1'b0;
    for (int i = 0; i < 40 * PERIOD && !found; i++) begin
      if (mode_m == 0 && led_m == 4'b0101 && !tick_m) found = 1'b1;
      else cycle();
    end
    check_eq("reach_cnt5", found, 1'b1);
    bus.mode = 2'd1;
    run(PERIOD * 4);

    // Asynchronous reset mid-cycle at walk 0100
    found = 1'b0;
    for (int i = 0; i < 20 * PERIOD && !found; i++) begin
      if (mode_m == 1 && led_m == 4'b0100) found = 1'b1;
      else cycle();
    end
    check_eq("reach_walk4", found, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_led", bus.led_o, 4'h0);
    check_eq("mid_rst_diff", bus.diff_o, 1'b0);
    check_eq("mid_rst_tick", bus.tick_o, 1'b0);
    model_reset();
    @(negedge clk);
    run(2);
    rst_n = 1'b1;
    run(PERIOD * 4);

    // Random enable, occasional mode changes and tick-cycle enable drops
    for (int i = 0; i < 800; i++) begin
      bus.en = ($urandom_range(0, 7) != 0);
      if (tick_m && $urandom_range(0, 2) == 0) bus.en = 1'b0;
      if ($urandom_range(0, 24) == 0) bus.mode = 2'($urandom_range(0, 3));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
